// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction memory, redirect and decode handshake bundle for inst_fetch_ctrl
interface inst_fetch_if;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fault;
  logic [31:0] fault_pc;
  modport master (
    output mem_addr, inst_valid, inst, inst_pc, fault, fault_pc,
    input  mem_data, redirect_valid, redirect_pc, halt_req, inst_ready
  );
  modport slave (
    input  mem_addr, inst_valid, inst, inst_pc, fault, fault_pc,
    output mem_data, redirect_valid, redirect_pc, halt_req, inst_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencer for word-addressed inst memory with 2-entry fetch buffer
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [29:0] MEM_LO   = 30'h0010_0000,
  parameter logic [29:0] MEM_HI   = 30'h0010_0100
) (
  input logic          clk,
  input logic          rst_n,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, fault_pc_q, fault_pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  count_q, count_d, slot;
  logic [63:0] e0_q, e0_d, e1_q, e1_d, word;
  logic        pc_ok, rd_ok, pop, fe, set_fault;

  function automatic logic legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a[31:2] >= MEM_LO && a[31:2] <= MEM_HI;
  endfunction

  assign pc_ok = legal(pc_q);
  assign rd_ok = legal(bus.redirect_pc);
  assign pop   = bus.inst_valid & bus.inst_ready;

  always_ff @(posedge clk)
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;

  // an illegal redirect out of FAULT stays there; the flag re-raises on the new pc
  always_comb
    state_d = bus.redirect_valid ? ((rd_ok || state_q != FAULT) ? RUN : FAULT)
            : state_q == RUN     ? (!pc_ok ? FAULT : bus.halt_req ? HALT : RUN)
            : state_q == HALT    ? (bus.halt_req ? HALT : RUN)
            : FAULT;

  always_comb begin
    fe        = state_q == RUN && !bus.halt_req && !bus.redirect_valid && pc_ok &&
                (count_q != 2'd2 || pop);
    set_fault = !bus.redirect_valid && !pc_ok && state_q != HALT && !fault_q;
  end

  // slot is where a push lands once this cycle's pop has shifted the queue
  always_comb begin
    word       = {pc_q, bus.mem_data};
    slot       = count_q - {1'b0, pop};
    pc_d       = bus.redirect_valid ? bus.redirect_pc : fe ? pc_q + 32'd4 : pc_q;
    count_d    = bus.redirect_valid ? 2'd0 : count_q + {1'b0, fe} - {1'b0, pop};
    e0_d       = (pop && count_q == 2'd2) ? e1_q : (fe && slot == 2'd0) ? word : e0_q;
    e1_d       = (fe && slot == 2'd1) ? word : e1_q;
    fault_d    = bus.redirect_valid ? 1'b0 : fault_q | set_fault;
    fault_pc_d = set_fault ? pc_q : fault_pc_q;
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      e0_q       <= 64'd0;
      e1_q       <= 64'd0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end

  assign bus.mem_addr   = pc_q[31:2];
  assign bus.inst_valid = count_q != 2'd0;
  assign bus.inst       = e0_q[31:0];
  assign bus.inst_pc    = e0_q[63:32];
  assign bus.fault      = fault_q;
  assign bus.fault_pc   = fault_pc_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: scoreboard bench with a queue-based fetch model plus directed scenarios
module tb_inst_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [29:0] LO     = 30'h0010_0000;
  localparam logic [29:0] HI     = 30'h0010_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  inst_fetch_if bus();
  inst_fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [29:0] off;
  assign off = bus.mem_addr - LO;
  assign bus.mem_data = mem[off[8:0]];

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  int mcount = 0;
  logic [31:0] mpc = RST_PC;
  logic [31:0] mfpc = 32'd0;
  bit mfault, halted, stopped, m_pop, m_fe, m_good;

  function automatic bit ok(input logic [31:0] a);
    return a[1:0] == 2'b00 && a[31:2] >= LO && a[31:2] <= HI;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [29:0] o;
    o = a[31:2] - LO;
    return mem[o[8:0]];
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: buffer is a queue of expected {pc,word}; state kept as halted/stopped flags
  always @(posedge clk) begin
    if (!rst_n) begin
      mpc = RST_PC; mcount = 0; exp_q.delete();
      halted = 0; stopped = 0; mfault = 0; mfpc = 32'd0;
    end else begin
      m_pop  = mcount > 0 && bus.inst_ready;
      m_good = ok(mpc);
      if (bus.redirect_valid) begin
        mcount = 0; exp_q.delete(); mfault = 0; halted = 0;
        stopped = stopped && !ok(bus.redirect_pc);
        mpc = bus.redirect_pc;
      end else begin
        m_fe = !halted && !stopped && !bus.halt_req && m_good && (mcount < 2 || m_pop);
        if (!halted && !m_good && !mfault) begin mfault = 1; mfpc = mpc; end
        if (!halted && !stopped && !m_good) stopped = 1;
        else if (!stopped) halted = bus.halt_req;
        mcount = mcount - int'(m_pop) + int'(m_fe);
        if (m_fe) begin
          exp_q.push_back({mpc, word_at(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake
  always @(negedge clk) begin
    chk("valid", {31'd0, bus.inst_valid}, {31'd0, mcount != 0});
    chk("fault", {31'd0, bus.fault}, {31'd0, mfault});
    chk("fault_pc", bus.fault_pc, mfpc);
    chk("mem_addr", {bus.mem_addr, 2'b00}, {mpc[31:2], 2'b00});
    if (bus.inst_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: unexpected inst_pc %h, want none", bus.inst_pc);
      end else begin
        chk("sb_inst_pc", bus.inst_pc, exp_q[0][63:32]);
        chk("sb_inst", bus.inst, exp_q[0][31:0]);
        if (bus.inst_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] w;
    int r, k;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    bus.inst_ready = 1'b1; bus.halt_req = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
    tick(); tick();
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst_addr", {bus.mem_addr, 2'b00}, RST_PC);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_pc", bus.inst_pc, RST_PC + 32'(4 * i));
      chk("t1_inst", bus.inst, mem[i]);
    end
    bus.inst_ready = 1'b0;
    repeat (5) tick();
    chk("t2_hold_pc", bus.inst_pc, 32'h0040_0008);
    chk("t2_hold_inst", bus.inst, mem[2]);
    chk("t2_pc_stop", {bus.mem_addr, 2'b00}, 32'h0040_0010);
    bus.inst_ready = 1'b1;
    tick(); chk("t2_order1", bus.inst_pc, 32'h0040_000C);
    tick(); chk("t2_order2", bus.inst_pc, 32'h0040_0010);
    bus.inst_ready = 1'b0;
    tick();
    bus.inst_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0040_0040;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_flush", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("t3_pc", bus.inst_pc, 32'h0040_0040);
    chk("t3_inst", bus.inst, mem[16]);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0040_03F8;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (3) tick();
    chk("t4_last_pc", bus.inst_pc, 32'h0040_0400);
    chk("t4_last_inst", bus.inst, mem[256]);
    tick();
    chk("t4_fault", {31'd0, bus.fault}, 32'd1);
    chk("t4_fault_pc", bus.fault_pc, 32'h0040_0404);
    chk("t4_drained", {31'd0, bus.inst_valid}, 32'd0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0040_0002;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_clear", {31'd0, bus.fault}, 32'd0);
    tick();
    chk("t5_fault", {31'd0, bus.fault}, 32'd1);
    chk("t5_fault_pc", bus.fault_pc, 32'h0040_0002);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0040_0000;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_recover", {31'd0, bus.fault}, 32'd0);
    tick();
    chk("t5_resume", bus.inst_pc, 32'h0040_0000);
    bus.halt_req = 1'b1; bus.inst_ready = 1'b0;
    tick();
    chk("t6_held", bus.inst_pc, 32'h0040_0000);
    bus.inst_ready = 1'b1;
    repeat (3) tick();
    chk("t6_drained", {31'd0, bus.inst_valid}, 32'd0);
    chk("t6_pc_held", {bus.mem_addr, 2'b00}, 32'h0040_0004);
    bus.halt_req = 1'b0;
    tick(); tick();
    chk("t6_resume", bus.inst_pc, 32'h0040_0004);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("t6_rst_inst", bus.inst, 32'd0);
    chk("t6_rst_pc", bus.inst_pc, 32'd0);
    chk("t6_rst_fpc", bus.fault_pc, 32'd0);
    rst_n = 1'b1;
    repeat (3000) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 9);
      bus.inst_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 19) == 0) bus.halt_req = ~bus.halt_req;
      bus.redirect_valid = r < 4;
      w = (k < 6) ? LO + 30'($urandom_range(0, 256)) : HI - 30'($urandom_range(0, 3));
      bus.redirect_pc = (k == 8) ? {w, 2'b10} : (k == 9) ? 32'($urandom) : {w, 2'b00};
      rst_n = r != 99;
      tick();
    end
    rst_n = 1'b1; bus.redirect_valid = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
